// File: rtl/mult_pkg.sv
// Shared types and sizing constants for the sequential multiplier.
package mult_pkg;

    localparam int MULT_WIDTH = 16;
    localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_e;

endpackage

// File: rtl/seq_mult.sv
// Sequential unsigned shift-add multiplier, one partial-product step per cycle.
// Optional macro SEQ_MULT_EARLY_EXIT_EN finishes as soon as the multiplier runs out of set bits.
module seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]     b_sh_q, b_sh_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic [WIDTH-1:0]     y_hi_q, y_hi_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;

    logic [2*WIDTH-1:0]   acc_step;
    logic                 last_step;

    assign acc_step = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    // Once the remaining multiplier bits are all zero, acc_step is already final.
    assign last_step = (cnt_q == LAST_CNT) || ((b_sh_q >> 1) == '0);
`else
    assign last_step = (cnt_q == LAST_CNT);
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        y_hi_d  = y_hi_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = {{WIDTH{1'b0}}, a};
                    b_sh_d  = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = WORK;
                end
            end
            WORK: begin
                acc_d  = acc_step;
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_step) begin
                    y_d     = acc_step[WIDTH-1:0];
                    y_hi_d  = acc_step[2*WIDTH-1:WIDTH];
                    ovf_d   = (acc_step[2*WIDTH-1:WIDTH] != '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            y_hi_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            y_hi_q  <= y_hi_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == WORK);
    assign done = done_q;
    assign y    = y_q;
    assign y_hi = y_hi_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: vector table, directed corner cases and random operands.
module tb_seq_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, ovf;
    logic [15:0] y, y_hi;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_prev = '0;

    seq_mult #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .y    (y),
        .y_hi (y_hi),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        logic [15:0] y_hi;
        logic        ovf;
    } vec_t;

    vec_t tbl[7];

    function automatic int exp_lat(input logic [15:0] bv);
        int l;
        l = 16;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        l = 1;
        for (int i = 0; i < 16; i++)
            if (bv[i]) l = i + 1;
`endif
        return l;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // One full transaction; glitch_at > 0 pulses a stray start with new operands mid-operation.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         input int glitch_at, input string name);
        logic [31:0] prod;
        int          n, busy_n, lat, extra;
        logic        hold_bad, seen;
        prod = 32'(ta) * 32'(tb_v);
        lat  = exp_lat(tb_v);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        chk({name, "_busy_after_accept"}, 64'(busy), 64'(1));
        n = 0; busy_n = 1; hold_bad = 1'b0; seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (n == glitch_at) begin
                a = 16'd7; b = 16'd7; start = 1'b1;
            end else if (n == glitch_at + 1) begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
            else begin
                if (busy) busy_n++;
                if ({y_hi, y} !== exp_prev) hold_bad = 1'b1;
            end
        end
        start = 1'b0;
        chk({name, "_done_seen"}, 64'(seen), 64'(1));
        chk({name, "_latency"}, 64'(n), 64'(lat));
        chk({name, "_busy_cycles"}, 64'(busy_n), 64'(lat));
        chk({name, "_busy_at_done"}, 64'(busy), 64'(0));
        chk({name, "_hold_prev"}, 64'(hold_bad), 64'(0));
        chk({name, "_y"}, 64'(y), 64'(prod[15:0]));
        chk({name, "_y_hi"}, 64'(y_hi), 64'(prod[31:16]));
        chk({name, "_ovf"}, 64'(ovf), 64'(prod[31:16] != 16'd0));
        $display("[TB] %s a=%0d b=%0d -> y_hi=%h y=%h ovf=%0b lat=%0d", name, ta, tb_v,
                 y_hi, y, ovf, n);
        exp_prev = prod;
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, 64'(done), 64'(0));
        if (glitch_at > 0) begin
            extra = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (done) extra++;
            end
            chk({name, "_single_done"}, 64'(extra), 64'(0));
        end
    endtask

    initial begin
        int          n, d1, d2, lat1, lat2;
        logic [15:0] ra, rb;

        tbl[0] = '{16'd3,      16'd5,      16'h000F, 16'h0000, 1'b0};
        tbl[1] = '{16'hFFFF,   16'hFFFF,   16'h0001, 16'hFFFE, 1'b1};
        tbl[2] = '{16'd100,    16'd3,      16'h012C, 16'h0000, 1'b0};
        tbl[3] = '{16'h1234,   16'h0000,   16'h0000, 16'h0000, 1'b0};
        tbl[4] = '{16'h0001,   16'h8000,   16'h8000, 16'h0000, 1'b0};
        tbl[5] = '{16'h8000,   16'h0002,   16'h0000, 16'h0001, 1'b1};
        tbl[6] = '{16'd100,    16'd200,    16'h4E20, 16'h0000, 1'b0};

        // Reset held with start active and random operands.
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            a = 16'($urandom); b = 16'($urandom);
            chk("reset_outputs", {29'd0, busy, done, ovf, y, y_hi}, 64'd0);
        end
        @(negedge clk);
        start = 1'b0; rst = 1'b1;

        // Vector table: constants cross-checked against plain multiplication.
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("tbl%0d_const", i), {31'd0, tbl[i].ovf, tbl[i].y_hi, tbl[i].y},
                {31'd0, (32'(tbl[i].a) * 32'(tbl[i].b)) > 32'hFFFF,
                 32'(tbl[i].a) * 32'(tbl[i].b)});
            do_op(tbl[i].a, tbl[i].b, -1, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_vec", i), {31'd0, ovf, y_hi, y},
                {31'd0, tbl[i].ovf, tbl[i].y_hi, tbl[i].y});
        end

        // Stray start mid-operation is ignored.
        do_op(16'd100, 16'd200, 3, "ignored_start");
        chk("ignored_start_y", 64'(y), 64'h4E20);

        // Asynchronous reset at step 8 aborts the operation.
        @(negedge clk);
        a = 16'd1234; b = 16'd567; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("midrst_busy_before", 64'(busy), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("midrst_outputs", {29'd0, busy, done, ovf, y, y_hi}, 64'd0);
        n = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        chk("midrst_no_done", 64'(n), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        exp_prev = '0;
        do_op(16'd2, 16'd9, -1, "after_reset");
        chk("after_reset_y", 64'(y), 64'd18);

        // start held high across a completion: ignored on that edge, accepted on the next.
        lat1 = exp_lat(16'd13);
        lat2 = exp_lat(16'd23);
        @(negedge clk);
        a = 16'd11; b = 16'd13; start = 1'b1;
        @(posedge clk); #1;
        a = 16'd21; b = 16'd23;
        n = 0; d1 = -1; d2 = -1;
        while (n < 60 && d2 < 0) begin
            @(posedge clk); #1;
            n++;
            if (d1 >= 0 && n == d1 + 1) begin
                chk("b2b_accept_busy", 64'(busy), 64'(1));
                start = 1'b0;
            end
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    chk("b2b_first_y", 64'(y), 64'd143);
                end else begin
                    d2 = n;
                    chk("b2b_second_y", 64'(y), 64'd483);
                end
            end
        end
        start = 1'b0;
        chk("b2b_first_lat", 64'(d1), 64'(lat1));
        chk("b2b_gap", 64'(d2 - d1), 64'(lat2 + 1));
        $display("[TB] back_to_back 11*13 then 21*23 dones at cycles %0d and %0d", d1, d2);
        exp_prev = 32'd483;

        // Random operands against the arithmetic model; small multipliers exercise short latency.
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            do_op(ra, rb, -1, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
